gf_add_scheduler: RTL and testbench

- Shares one combinational GF_Adder modular adder among NREQ requesters; each requester issues one modular-arithmetic job at a time.
- Round-robin arbitration; jobs are sequenced over one or two adder passes (ADD, DBL, TPL).
- Results return on a single shared response channel with backpressure.
- Sits between the point-arithmetic sequencers and the field datapath.

---
 rtl/gf_add_scheduler_pkg.sv | 22 ++
 rtl/gf_add_scheduler_if.sv | 30 +++
 rtl/gf_add_scheduler_rr_arbiter.sv | 38 +++
 rtl/gf_adder.sv | 19 +
 rtl/gf_add_scheduler.sv | 133 +++++++++++++
 tb/tb_gf_add_scheduler.sv | 231 +++++++++++++++++++++++
 6 files changed

// File: rtl/gf_add_scheduler_pkg.sv
// Shared types and defaults for the GF adder scheduler.
package gf_sched_pkg;

  localparam int unsigned DEF_W    = 256;
  localparam int unsigned DEF_NREQ = 4;
  localparam int unsigned DEF_IDW  = 2;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_DBL = 2'b01,
    OP_TPL = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PASS1 = 2'b01,
    ST_PASS2 = 2'b10,
    ST_RESP  = 2'b11
  } state_e;

endpackage

// File: rtl/gf_add_scheduler_if.sv
// Request/response bundle between requesters and the scheduler.
interface gf_add_scheduler_if import gf_sched_pkg::*; #(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned W    = DEF_W,
  parameter int unsigned IDW  = DEF_IDW
) ();

  logic [W-1:0]        p;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [2*NREQ-1:0]   req_op;
  logic [W*NREQ-1:0]   req_a;
  logic [W*NREQ-1:0]   req_b;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [W-1:0]        rsp_data;
  logic                rsp_err;

  modport master (
    output p, req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport slave (
    input  p, req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );

endinterface

// File: rtl/gf_add_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, wrapping.
module gf_rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  input  logic            en_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  idx_o
);

  logic        found;
  int unsigned ptr_w;

  // Two scans (upper then wrapped lower) keep every index a loop constant.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    ptr_w   = 32'(ptr_i);
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (en_i && !found && (i >= ptr_w) && req_i[i]) begin
        grant_o[i] = 1'b1;
        idx_o      = IDW'(i);
        found      = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (en_i && !found && (i < ptr_w) && req_i[i]) begin
        grant_o[i] = 1'b1;
        idx_o      = IDW'(i);
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gf_adder.sv
// Combinational modular adder: (a + b) mod p for a, b < p.
module GF_Adder #(
  parameter int unsigned W = 256
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] p_i,
  output logic [W-1:0] sum_o
);

  logic [W:0] raw;

  // Single conditional subtraction suffices because both operands are < p.
  always_comb begin
    raw   = {1'b0, a_i} + {1'b0, b_i};
    sum_o = (raw >= {1'b0, p_i}) ? W'(raw - {1'b0, p_i}) : raw[W-1:0];
  end

endmodule

// File: rtl/gf_add_scheduler.sv
// Shares one GF_Adder among NREQ requesters; ADD/DBL take one pass, TPL two.
module gf_add_scheduler import gf_sched_pkg::*; #(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned W    = DEF_W,
  parameter int unsigned IDW  = DEF_IDW
) (
  input  logic               clk,
  input  logic               rst,
  gf_add_scheduler_if.slave  bus
);

  state_e          state_q;
  op_e             op_q;
  logic [IDW-1:0]  rr_ptr_q, id_q;
  logic [W-1:0]    p_q, a_q, b_q, acc_q;
  logic            rsp_valid_q, rsp_err_q;
  logic [IDW-1:0]  rsp_id_q;
  logic [W-1:0]    rsp_data_q;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx, rr_ptr_d;
  op_e             sel_op;
  logic [W-1:0]    sel_a, sel_b, add_x, add_y, sum;

  gf_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req_i   (bus.req_valid),
    .ptr_i   (rr_ptr_q),
    .en_i    ((state_q == ST_IDLE) && !rst),
    .grant_o (grant),
    .idx_o   (grant_idx)
  );

  // Select the granted requester's payload.
  always_comb begin
    sel_op = OP_ADD;
    sel_a  = '0;
    sel_b  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_op = op_e'(bus.req_op[2*i +: 2]);
        sel_a  = bus.req_a[W*i +: W];
        sel_b  = bus.req_b[W*i +: W];
      end
    end
    rr_ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
  end

  // Adder operand mux: second TPL pass adds a once more to the first-pass sum.
  always_comb begin
    add_x = (state_q == ST_PASS2) ? acc_q : a_q;
    add_y = (state_q == ST_PASS2) ? a_q   : b_q;
  end

  GF_Adder #(.W(W)) u_add (
    .a_i   (add_x),
    .b_i   (add_y),
    .p_i   (p_q),
    .sum_o (sum)
  );

  // Job sequencing FSM with registered response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_ADD;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      p_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|grant) begin
            p_q      <= bus.p;
            a_q      <= sel_a;
            b_q      <= (sel_op == OP_ADD) ? sel_b : sel_a;
            op_q     <= sel_op;
            id_q     <= grant_idx;
            rr_ptr_q <= rr_ptr_d;
            if (sel_op == OP_RSV) begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_data_q  <= '0;
              rsp_id_q    <= grant_idx;
              state_q     <= ST_RESP;
            end else begin
              state_q     <= ST_PASS1;
            end
          end
        end
        ST_PASS1: begin
          acc_q <= sum;
          if (op_q == OP_TPL) begin
            state_q <= ST_PASS2;
          end else begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= sum;
            rsp_id_q    <= id_q;
            state_q     <= ST_RESP;
          end
        end
        ST_PASS2: begin
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_data_q  <= sum;
          rsp_id_q    <= id_q;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready = grant;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_gf_add_scheduler.sv
// Scoreboard bench for gf_add_scheduler with directed, hand-computed vectors (p = 97).
module tb_gf_add_scheduler;
  import gf_sched_pkg::*;

  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 256;
  localparam int unsigned IDW  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gf_add_scheduler_if #(.NREQ(NREQ), .W(W), .IDW(IDW)) bus ();

  gf_add_scheduler #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [IDW-1:0] id;
    logic [W-1:0]   data;
    logic           err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic expect_true(input string name, input logic cond);
    total++;
    if (cond !== 1'b1) begin
      bad++;
      $display("FAIL %s got=0 want=1", name);
    end
  endtask

  task automatic push_exp(input int unsigned id, input int unsigned data, input logic err);
    exp_t e;
    e.id   = IDW'(id);
    e.data = W'(data);
    e.err  = err;
    sb.push_back(e);
  endtask

  // Monitor: grant sanity every cycle, and pop/compare on each response handshake.
  always @(negedge clk) begin
    exp_t e;
    expect_true("grant_onehot0", $onehot0(bus.req_ready));
    expect_true("grant_only_valid", (bus.req_ready & ~bus.req_valid) == '0);
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp got id=%0d data=%0d want none", bus.rsp_id, bus.rsp_data);
      end else begin
        e = sb.pop_front();
        check("rsp_id", W'(bus.rsp_id), W'(e.id));
        check("rsp_data", bus.rsp_data, e.data);
        check("rsp_err", W'(bus.rsp_err), W'(e.err));
      end
    end
  end

  // Wait (bounded) at negedges until requester r is granted.
  task automatic wait_grant(input int unsigned r, input string name);
    int t;
    t = 0;
    @(negedge clk);
    while (!bus.req_ready[r] && t < 40) begin
      @(negedge clk);
      t++;
    end
    expect_true(name, bus.req_ready[r]);
  endtask

  // Issue one job, push its expected response, and check accept-to-valid latency.
  task automatic issue(input int unsigned r, input logic [1:0] op, input int unsigned a,
                       input int unsigned b, input int unsigned exp_data, input logic exp_err,
                       input int exp_lat);
    int n;
    bus.req_op[2*r +: 2] = op;
    bus.req_a[W*r +: W]  = W'(a);
    bus.req_b[W*r +: W]  = W'(b);
    bus.req_valid[r]     = 1'b1;
    wait_grant(r, "issue_grant");
    push_exp(r, exp_data, exp_err);
    @(posedge clk);
    #1;
    bus.req_valid[r] = 1'b0;
    n = 1;
    while (!bus.rsp_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", W'(n), W'(exp_lat));
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    expect_true("drain", sb.size() == 0);
  endtask

  int unsigned rr_exp [4] = '{91, 4, 14, 24};
  int unsigned order  [5] = '{0, 1, 2, 3, 0};

  initial begin
    logic [IDW-1:0] gidx;
    int t;

    bus.p         = W'(97);
    bus.rsp_ready = 1'b1;
    bus.req_op    = '0;
    bus.req_valid = '0;
    // Round-robin payloads: req i adds (10*i+1) + 90 mod 97; all valid from reset.
    for (int i = 0; i < 4; i++) begin
      bus.req_a[W*i +: W] = W'(10 * i + 1);
      bus.req_b[W*i +: W] = W'(90);
    end
    bus.req_valid = '1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", W'(bus.rsp_valid), W'(0));
    check("rst_rsp_id", W'(bus.rsp_id), W'(0));
    check("rst_rsp_data", bus.rsp_data, W'(0));
    check("rst_rsp_err", W'(bus.rsp_err), W'(0));
    check("rst_req_ready", W'(bus.req_ready), W'(0));
    check("rst_state", W'(dut.state_q), W'(ST_IDLE));
    check("rst_rr_ptr", W'(dut.rr_ptr_q), W'(0));
    rst = 1'b0;

    // Round-robin with all requesters continuously valid.
    for (int g = 0; g < 5; g++) begin
      t = 0;
      @(negedge clk);
      while (!(|bus.req_ready) && t < 40) begin
        @(negedge clk);
        t++;
      end
      expect_true("rr_onehot", $onehot(bus.req_ready));
      gidx = '0;
      for (int i = 0; i < 4; i++) if (bus.req_ready[i]) gidx = IDW'(i);
      check("rr_grant_order", W'(gidx), W'(order[g]));
      push_exp(order[g], rr_exp[order[g]], 1'b0);
      @(posedge clk);
      #1;
      if (g == 4) bus.req_valid = '0;
    end
    drain();

    // Directed single jobs.
    issue(0, OP_ADD, 50, 60, 13, 1'b0, 2);
    issue(1, OP_DBL, 60, 0, 23, 1'b0, 2);
    issue(1, OP_TPL, 40, 0, 23, 1'b0, 3);
    issue(2, OP_RSV, 7, 0, 0, 1'b1, 1);
    drain();

    // Backpressure: hold RESP for 5 cycles while req0 waits.
    bus.rsp_ready = 1'b0;
    issue(3, OP_ADD, 96, 96, 95, 1'b0, 2);
    bus.req_op[1:0]   = OP_ADD;
    bus.req_a[W-1:0]  = W'(5);
    bus.req_b[W-1:0]  = W'(7);
    bus.req_valid[0]  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_rsp_valid", W'(bus.rsp_valid), W'(1));
      check("bp_rsp_data", bus.rsp_data, W'(95));
      check("bp_rsp_id", W'(bus.rsp_id), W'(3));
      check("bp_req_ready", W'(bus.req_ready), W'(0));
    end
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_next_grant", W'(bus.req_ready), W'(1));
    push_exp(0, 12, 1'b0);
    @(posedge clk);
    #1;
    bus.req_valid[0] = 1'b0;
    drain();

    // Reset during the second TPL pass: job is dropped silently.
    bus.req_op[3:2]     = OP_TPL;
    bus.req_a[W +: W]   = W'(40);
    bus.req_valid[1]    = 1'b1;
    wait_grant(1, "tpl_rst_grant");
    @(posedge clk);
    #1;
    bus.req_valid[1] = 1'b0;
    @(posedge clk);
    #1;
    check("tpl_in_pass2", W'(dut.state_q), W'(ST_PASS2));
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_rsp_valid", W'(bus.rsp_valid), W'(0));
    check("midrst_rsp_data", bus.rsp_data, W'(0));
    check("midrst_rsp_id", W'(bus.rsp_id), W'(0));
    check("midrst_rsp_err", W'(bus.rsp_err), W'(0));
    check("midrst_state", W'(dut.state_q), W'(ST_IDLE));
    check("midrst_rr_ptr", W'(dut.rr_ptr_q), W'(0));
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    issue(2, OP_ADD, 30, 40, 70, 1'b0, 2);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
